// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Holds the loader state encoding and the byte width of the incoming stream.
package prog_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Loader-facing bus: control, byte-stream handshake and program-memory write port.
// The master modport drives the stream; the slave modport is the loader itself.
interface prog_loader_if
   import prog_loader_pkg::*;
#(
   parameter int p_size = 6,
   parameter int i_size = 24
);

   logic              start;
   logic [p_size:0]   n_instr;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              wr_en;
   logic [p_size-1:0] wr_addr;
   logic [i_size-1:0] wr_data;
   logic              cpu_hold;
   logic              done;
   logic              err;

   modport master (
      output start, n_instr, rx_data, rx_valid,
      input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
   );

   modport slave (
      input  start, n_instr, rx_data, rx_valid,
      output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
   );

endinterface

// File: rtl/prog_loader_instr_assembler.sv
// Packs accepted bytes MSB-first into one instruction word; flags the cycle
// in which the final byte of a word is accepted, with the full word alongside.
module instr_assembler
   import prog_loader_pkg::*;
#(
   parameter int i_size = 24
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_in,
   output logic              word_done,
   output logic [i_size-1:0] word
);

   localparam int B  = i_size / BYTE_W;
   localparam int CW = $clog2(B + 1);
   localparam logic [CW-1:0] LAST = CW'(B - 1);

   logic [CW-1:0]     cnt;
   logic [i_size-1:0] shreg;

   // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
   always_comb begin
      word      = (shreg << BYTE_W) | i_size'(byte_in);
      word_done = byte_valid && (cnt == LAST);
   end

   // NOTE: the shift register is reset with the counter so an aborted load leaves no stale byte behind.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (clear) begin
         cnt   <= '0;
      end else if (byte_valid) begin
         shreg <= word;
         cnt   <= word_done ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Program loader top: FSM, instruction index, output registers and optional
// XOR checksum of the byte stream (enabled by defining PROG_LOADER_CHECKSUM_EN).
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int p_size  = 6,
   parameter int i_size  = 24,
   parameter int p_depth = 16
) (
   input logic          Clock,
   input logic          Reset,
   prog_loader_if.slave bus
);

   localparam logic [p_size:0] DEPTH = (p_size + 1)'(p_depth);
   localparam logic [p_size:0] ONE   = (p_size + 1)'(1);

   state_t            state;
   logic [p_size:0]   index;
   logic [p_size:0]   target;
   logic [p_size:0]   n_sat;
   logic              rx_ready_q;
   logic              cpu_hold_q;
   logic              done_q;
   logic              wr_en_q;
   logic [p_size-1:0] wr_addr_q;
   logic [i_size-1:0] wr_data_q;
   logic              accept;
   logic              byte_valid;
   logic              word_done;
   logic [i_size-1:0] word;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] acc;
   logic              err_q;
`endif

   assign n_sat      = (bus.n_instr > DEPTH) ? DEPTH : bus.n_instr;
   assign accept     = bus.rx_valid && rx_ready_q;
   // A byte arriving together with start is dropped, never assembled.
   assign byte_valid = accept && !bus.start && (state == LOAD);

   instr_assembler #(.i_size(i_size)) u_asm (
      .Clock     (Clock),
      .Reset     (Reset),
      .clear     (bus.start),
      .byte_valid(byte_valid),
      .byte_in   (bus.rx_data),
      .word_done (word_done),
      .word      (word)
   );

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         index      <= '0;
         target     <= '0;
         rx_ready_q <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         acc        <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         wr_en_q <= 1'b0;
         if (bus.start) begin
            index  <= '0;
            target <= n_sat;
            done_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc    <= '0;
            err_q  <= 1'b0;
`endif
            if (n_sat == '0) begin
               state      <= DONE;
               done_q     <= 1'b1;
               rx_ready_q <= 1'b0;
               cpu_hold_q <= 1'b0;
            end else begin
               state      <= LOAD;
               rx_ready_q <= 1'b1;
               cpu_hold_q <= 1'b1;
            end
         end else begin
            case (state)
               LOAD: begin
                  if (byte_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                     acc <= acc ^ bus.rx_data;
`endif
                     if (word_done) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= index[p_size-1:0];
                        wr_data_q <= word;
                        index     <= index + ONE;
                        if ((index + ONE) == target) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                           state      <= CHECK;
`else
                           state      <= DONE;
                           done_q     <= 1'b1;
                           rx_ready_q <= 1'b0;
                           cpu_hold_q <= 1'b0;
`endif
                        end
                     end
                  end
               end
`ifdef PROG_LOADER_CHECKSUM_EN
               CHECK: begin
                  if (accept) begin
                     err_q      <= (bus.rx_data != acc);
                     done_q     <= 1'b1;
                     state      <= DONE;
                     rx_ready_q <= 1'b0;
                     cpu_hold_q <= 1'b0;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign bus.rx_ready = rx_ready_q;
   assign bus.cpu_hold = cpu_hold_q;
   assign bus.done     = done_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   assign bus.err      = err_q;
`else
   assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: drives byte streams, queues expected writes,
// and checks handshake/status outputs every cycle (honours PROG_LOADER_CHECKSUM_EN).
module tb_prog_loader;

   localparam int P_SIZE  = 6;
   localparam int I_SIZE  = 24;
   localparam int P_DEPTH = 16;
   localparam int B       = I_SIZE / 8;

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   prog_loader_if #(.p_size(P_SIZE), .i_size(I_SIZE)) bus ();

   prog_loader #(.p_size(P_SIZE), .i_size(I_SIZE), .p_depth(P_DEPTH)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int                cyc;
      int                addr;
      logic [I_SIZE-1:0] data;
   } wr_exp_t;

   typedef enum {M_IDLE, M_LOAD, M_CHECK, M_DONE} mphase_t;

   wr_exp_t           exp_q[$];
   mphase_t           m_phase = M_IDLE;
   int                m_target = 0;
   int                m_cnt = 0;
   int                m_idx = 0;
   logic [I_SIZE-1:0] m_word = '0;
   logic [7:0]        m_acc = '0;
   logic              m_err = 1'b0;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int writes = 0;
   int w0;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_phase = M_IDLE;
      m_cnt   = 0;
      m_idx   = 0;
      m_word  = '0;
      m_acc   = '0;
      m_err   = 1'b0;
   endtask

   task automatic model_start(input int n);
      int sat;
      sat      = (n > P_DEPTH) ? P_DEPTH : n;
      m_target = sat;
      m_cnt    = 0;
      m_idx    = 0;
      m_word   = '0;
      m_acc    = '0;
      m_err    = 1'b0;
      m_phase  = (sat == 0) ? M_DONE : M_LOAD;
   endtask

   // Called just after the edge that accepted byte b.
   task automatic model_byte(input logic [7:0] b);
      case (m_phase)
         M_LOAD: begin
            m_acc  = m_acc ^ b;
            m_word = {m_word[I_SIZE-9:0], b};
            m_cnt++;
            if (m_cnt == B) begin
               m_cnt = 0;
               exp_q.push_back('{cyc, m_idx, m_word});
               m_idx++;
               if (m_idx == m_target) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  m_phase = M_CHECK;
`else
                  m_phase = M_DONE;
`endif
               end
            end
         end
         M_CHECK: begin
            m_err   = (b != m_acc);
            m_phase = M_DONE;
         end
         default: ;
      endcase
   endtask

   task automatic do_start(input int n, input logic with_byte);
      @(negedge Clock);
      bus.start    = 1'b1;
      bus.n_instr  = 7'(n);
      bus.rx_valid = with_byte;
      bus.rx_data  = 8'hEE;
      @(posedge Clock);
      #1;
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      model_start(n);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic ok;
      @(negedge Clock);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      ok = bus.rx_ready;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge Clock);
         ok = bus.rx_ready;
      end
      if (!ok) begin
         check("rx_ready_wait", 0, 1);
      end else begin
         @(posedge Clock);
         #1;
         model_byte(b);
      end
   endtask

   task automatic gap();
      @(negedge Clock);
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int k);
      gap();
      repeat (k) @(negedge Clock);
   endtask

   task automatic finish_cks();
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(m_acc);
`endif
   endtask

   // Per-cycle status check plus write-port scoreboard.
   always @(negedge Clock) begin
      if (!Reset) begin
         check("rx_ready", bus.rx_ready, (m_phase == M_LOAD) || (m_phase == M_CHECK));
         check("cpu_hold", bus.cpu_hold, (m_phase == M_LOAD) || (m_phase == M_CHECK));
         check("done", bus.done, m_phase == M_DONE);
         check("err", bus.err, m_err);
         if (bus.wr_en) begin
            writes <= writes + 1;
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 1, 0);
            end else begin
               check("wr_addr", bus.wr_addr, exp_q[0].addr);
               check("wr_data", bus.wr_data, exp_q[0].data);
               check("wr_cycle", cyc, exp_q[0].cyc);
               exp_q.pop_front();
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            check("wr_en_missing", 0, 1);
            exp_q.pop_front();
         end
      end
   end

   initial begin
      bus.start    = 1'b0;
      bus.n_instr  = '0;
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;

      repeat (3) @(negedge Clock);
      #1;
      check("reset_status", {bus.rx_ready, bus.cpu_hold, bus.done, bus.err, bus.wr_en}, 0);
      check("reset_wr_bus", {bus.wr_addr, bus.wr_data}, 0);
      @(negedge Clock);
      #2 Reset = 1'b0;

      // Abort after two bytes, then a single-word load.
      do_start(1, 1'b0);
      send_byte(8'h01);
      send_byte(8'h02);
      @(negedge Clock);
      #2;
      Reset        = 1'b1;
      bus.rx_valid = 1'b0;
      model_reset();
      #1;
      check("abort_status", {bus.rx_ready, bus.cpu_hold, bus.done, bus.err, bus.wr_en}, 0);
      check("abort_wr_bus", {bus.wr_addr, bus.wr_data}, 0);
      @(negedge Clock);
      #2 Reset = 1'b0;
      do_start(1, 1'b0);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      finish_cks();
      idle(3);

      // Three words back-to-back.
      do_start(3, 1'b0);
      for (int i = 1; i <= 9; i++) send_byte(8'(i * 8'h11));
      finish_cks();
      idle(3);

      // Two words with one-cycle gaps between bytes.
      do_start(2, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         send_byte(8'(8'hC0 + i));
         gap();
      end
      finish_cks();
      idle(3);

      // Zero instructions: immediate DONE, no writes.
      w0 = writes;
      do_start(0, 1'b0);
      idle(3);
      check("n0_writes", writes - w0, 0);

      // Oversized count saturates to the memory depth; bytes in DONE are ignored.
      w0 = writes;
      do_start(31, 1'b0);
      for (int i = 0; i < P_DEPTH * B; i++) send_byte(8'(i * 7 + 3));
      finish_cks();
      @(negedge Clock);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hFF;
      repeat (3) @(negedge Clock);
      idle(3);
      check("n31_writes", writes - w0, P_DEPTH);

      // Restart mid-load; the byte coincident with start is discarded.
      do_start(2, 1'b0);
      for (int i = 1; i <= 4; i++) send_byte(8'(8'hA0 + i));
      do_start(2, 1'b1);
      for (int i = 1; i <= 6; i++) send_byte(8'(8'hB0 + i));
      finish_cks();
      idle(3);

`ifdef PROG_LOADER_CHECKSUM_EN
      do_start(1, 1'b0);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h00);
      idle(2);
      check("cks_good_done", bus.done, 1);
      check("cks_good_err", bus.err, 0);
      do_start(1, 1'b0);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h5A);
      idle(2);
      check("cks_bad_done", bus.done, 1);
      check("cks_bad_err", bus.err, 1);
`endif

      idle(4);
      check("pending_writes", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the processor's writable program memory at start-up. It accepts 8-bit bytes over a valid/ready handshake and assembles them MSB-first into `i_size`-bit instruction words. It writes those words to consecutive program-memory addresses starting at 0, and holds the CPU while loading. It is the write-side counterpart of the instruction-fetch read port.

## Interface
- `p_size`, 6, program address width
- `i_size`, 24, instruction width; multiple of 8
- `p_depth`, 16, number of program-memory entries; must be ≤ 2**`p_size`
- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins (or restarts) a load
- `n_instr`  in  `p_size`+1  instruction count, sampled on `start`; values above `p_depth` saturate to `p_depth`
- `rx_data`  in  8  incoming program byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader accepts a byte this cycle
- `wr_en`  out  1  program-memory write strobe, one cycle per instruction
- `wr_addr`  out  `p_size`  write address
- `wr_data`  out  `i_size`  assembled instruction
- `cpu_hold`  out  1  keeps the processor stalled while high
- `done`  out  1  load complete; level signal
- `err`  out  1  checksum mismatch; only active with the checksum feature enabled

## Operation
- B = `i_size`/8 bytes per instruction. A byte transfers when `rx_valid` & `rx_ready`. The first byte received is bits [`i_size`-1:`i_size`-8].
- States:
  - IDLE: `rx_ready`=0 and `cpu_hold`=0.
  - LOAD: `rx_ready`=1 and `cpu_hold`=1.
  - CHECK: `rx_ready`=1 and `cpu_hold`=1. Exists only when the checksum feature is enabled.
  - DONE: `rx_ready`=0, `cpu_hold`=0, `done`=1.
- `start` from any state clears the byte counter, instruction index, `err`, `done` and the checksum accumulator, then:
  - goes to LOAD;
  - or goes to DONE directly if the saturated `n_instr` is 0, with no writes.
- LOAD: on the B-th accepted byte of an instruction:
  - the word is written to address = index;
  - the index increments;
  - the byte counter wraps to 0.
- When index reaches `n_instr`, the next state is CHECK if the checksum feature is enabled, otherwise DONE.
- `rx_valid` gaps of any length are allowed; the partial word is retained.
- `rx_valid` is ignored in IDLE and DONE.
- Addresses at or above `n_instr` are never written; their prior contents remain.
- `start` in the same cycle as a byte handshake: `start` wins and the byte is discarded.

## Timing
- Reset values: all outputs 0; state IDLE.
- `rx_ready` is a registered state decode. It drops in the cycle after the final byte is accepted.
- `wr_en`, `wr_addr` and `wr_data` are registered and assert one cycle after the B-th byte handshake. `wr_en` lasts exactly one cycle.
- `done` rises in the same cycle as the final `wr_en` (no-checksum build), and one cycle after the checksum-byte handshake (checksum build). It stays high until `start` or `Reset`.
- `Reset` mid-load aborts immediately. Any partial word is discarded and no write is issued.
- Throughput: one byte per cycle, so one instruction write every B cycles.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - after the last instruction the loader enters CHECK and accepts one byte;
  - if that byte ≠ the XOR of all data bytes loaded since `start`, `err`=1 together with `done`;
  - `cpu_hold` stays high through CHECK.
- Undefined:
  - no CHECK state and no accumulator;
  - `err` is tied to 0;
  - no extra byte is consumed.

## Structure
- Package `prog_loader_pkg`: the state enum typedef (IDLE, LOAD, CHECK, DONE) and constant `BYTE_W`=8.
- Sub-module `instr_assembler`: B-deep byte shift register plus byte counter. It emits a one-cycle word-complete flag and the assembled word. The top level holds the FSM, index counter, checksum and output registers.

## Test plan
- Reset asserted mid-stream after 2 bytes → all outputs 0 in the same cycle. After release, `start` with `n_instr`=1 and bytes 01,02,03 → a single write of 010203 to address 0.
- `start`, `n_instr`=3, bytes 11 22 33 44 55 66 77 88 99 back-to-back → `wr_en` pulses writing 112233@0, 445566@1, 778899@2, each one cycle after the 3rd/6th/9th byte. `done`=1 with the last pulse and `rx_ready`=0 afterwards.
- `n_instr`=2 with `rx_valid` toggling every other cycle → the same words as contiguous input; no spurious `wr_en`.
- `n_instr`=0 → DONE the cycle after `start`, zero writes. `n_instr`=31 → exactly 16 writes, addresses 0–15.
- `start` reissued after 4 of 6 bytes → index restarts at 0 and the next 6 bytes land at addresses 0 and 1.
- With `PROG_LOADER_CHECKSUM_EN`, bytes 01 02 03:
  - checksum 00 → `done`=1, `err`=0;
  - checksum 5A → `done`=1, `err`=1.
